// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined multiplier: default widths, operand
// extension helper and the default stage payload layout.
package mult_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 8;
  localparam int unsigned DEFAULT_TAG_WIDTH  = 4;
  localparam int unsigned MAX_WORD_WIDTH     = 64;

  typedef struct packed {
    logic [2*DEFAULT_WORD_WIDTH-1:0] product;
    logic [DEFAULT_TAG_WIDTH-1:0]    tag;
  } stage_payload_t;

  // Extends the low 'width' bits of value by one bit (sign or zero fill); the
  // fill is replicated up to the full return width so callers may slice freely.
  function automatic logic [MAX_WORD_WIDTH:0] extend_operand(
    input logic [MAX_WORD_WIDTH-1:0] value,
    input logic                      is_signed,
    input int unsigned               width
  );
    logic                    fill;
    logic [5:0]              sign_idx;
    logic [6:0]              idx;
    logic [MAX_WORD_WIDTH:0] result;
    sign_idx = 6'(width - 1);
    fill     = is_signed & value[sign_idx];
    result   = {1'b0, value};
    for (int unsigned i = 0; i <= MAX_WORD_WIDTH; i++) begin
      idx = 7'(i);
      if (i >= width) result[idx] = fill;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipelined_multiplier_pipe_stage.sv
// One elastic register stage: loads whenever it is empty or its downstream
// neighbour advances in the same cycle.
module pipe_stage #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter bit          RESET_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  load,
  input  logic                  down_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  assign load = !valid || down_ready;

  always_ff @(posedge clk) begin
    if (reset)     valid <= 1'b0;
    else if (load) valid <= up_valid;
  end

  // Data only moves on a real transfer, so an emptied stage keeps its last value.
  generate
    if (RESET_DATA) begin : g_reset_data
      always_ff @(posedge clk) begin
        if (reset)                data <= '0;
        else if (load && up_valid) data <= up_data;
      end
    end else begin : g_plain_data
      always_ff @(posedge clk) begin
        if (load && up_valid) data <= up_data;
      end
    end
  endgenerate

endmodule

// File: rtl/pipelined_multiplier.sv
// Elastic pipelined multiplier with per-operand signedness and a sideband tag;
// the product is formed combinationally ahead of a chain of pipe_stage registers.
module pipelined_multiplier #(
  parameter int unsigned WORD_WIDTH  = mult_pkg::DEFAULT_WORD_WIDTH,
  parameter int unsigned PIPE_STAGES = 3,
  parameter int unsigned TAG_WIDTH   = mult_pkg::DEFAULT_TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_WIDTH-1:0]   a,
  input  logic [WORD_WIDTH-1:0]   b,
  input  logic                    a_signed,
  input  logic                    b_signed,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WORD_WIDTH-1:0] y,
  output logic [TAG_WIDTH-1:0]    out_tag
);
  import mult_pkg::*;

  localparam int unsigned PROD_WIDTH = 2 * WORD_WIDTH;
  localparam int unsigned FULL_WIDTH = 2 * WORD_WIDTH + 2;

  typedef struct packed {
    logic [PROD_WIDTH-1:0] product;
    logic [TAG_WIDTH-1:0]  tag;
  } payload_t;

  localparam int unsigned PAYLOAD_WIDTH = $bits(payload_t);

  logic [MAX_WORD_WIDTH-1:0]    a_wide, b_wide;
  logic [MAX_WORD_WIDTH:0]      a_tmp, b_tmp;
  logic [WORD_WIDTH:0]          a_ext, b_ext;
  logic signed [FULL_WIDTH-1:0] a_full, b_full, full_product;
  payload_t                     in_payload;
  logic                         unused_bits;

  // (W+1)x(W+1) signed multiply covers all four signedness modes exactly.
  always_comb begin
    a_wide                   = '0;
    b_wide                   = '0;
    a_wide[WORD_WIDTH-1:0]   = a;
    b_wide[WORD_WIDTH-1:0]   = b;
    a_tmp                    = extend_operand(a_wide, a_signed, WORD_WIDTH);
    b_tmp                    = extend_operand(b_wide, b_signed, WORD_WIDTH);
    a_ext                    = a_tmp[WORD_WIDTH:0];
    b_ext                    = b_tmp[WORD_WIDTH:0];
    a_full                   = {{(WORD_WIDTH+1){a_ext[WORD_WIDTH]}}, a_ext};
    b_full                   = {{(WORD_WIDTH+1){b_ext[WORD_WIDTH]}}, b_ext};
    full_product             = a_full * b_full;
    in_payload.product       = full_product[PROD_WIDTH-1:0];
    in_payload.tag           = in_tag;
  end

  assign unused_bits = ^{a_tmp, b_tmp, full_product};

  // Ready chain runs from the output stage back to stage 0 through each load.
  generate
    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      logic     up_valid;
      payload_t up_data;
      logic     down_ready;
      logic     load;
      logic     valid;
      payload_t data;

      if (k == 0) begin : g_first
        assign up_valid = in_valid;
        assign up_data  = in_payload;
      end else begin : g_mid
        assign up_valid = g_stage[k-1].valid;
        assign up_data  = g_stage[k-1].data;
      end

      if (k == PIPE_STAGES - 1) begin : g_last
        assign down_ready = out_ready;
      end else begin : g_inner
        assign down_ready = g_stage[k+1].load;
      end

      pipe_stage #(
        .DATA_WIDTH (PAYLOAD_WIDTH),
        .RESET_DATA (k == PIPE_STAGES - 1)
      ) u_stage (
        .clk        (clk),
        .reset      (reset),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .load       (load),
        .down_ready (down_ready),
        .valid      (valid),
        .data       (data)
      );
    end
  endgenerate

  assign in_ready  = g_stage[0].load;
  assign out_valid = g_stage[PIPE_STAGES-1].valid;
  assign y         = g_stage[PIPE_STAGES-1].data.product;
  assign out_tag   = g_stage[PIPE_STAGES-1].data.tag;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Scoreboard bench: drivers push hand-computed products, negedge monitors pop
// and compare on every output transfer. Two builds: 8-bit/3-stage and 16-bit/1-stage.
module tb_pipelined_multiplier;

  localparam int unsigned S1 = 3;
  localparam int unsigned S2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        in_valid1, in_ready1, a_signed1, b_signed1, out_valid1, out_ready1;
  logic [7:0]  a1, b1;
  logic [3:0]  in_tag1, out_tag1;
  logic [15:0] y1;

  logic        in_valid2, in_ready2, a_signed2, b_signed2, out_valid2, out_ready2;
  logic [15:0] a2, b2;
  logic [3:0]  in_tag2, out_tag2;
  logic [31:0] y2;

  pipelined_multiplier #(.WORD_WIDTH(8), .PIPE_STAGES(S1), .TAG_WIDTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .a_signed(a_signed1), .b_signed(b_signed1), .in_tag(in_tag1),
    .out_valid(out_valid1), .out_ready(out_ready1), .y(y1), .out_tag(out_tag1)
  );

  pipelined_multiplier #(.WORD_WIDTH(16), .PIPE_STAGES(S2), .TAG_WIDTH(4)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .a_signed(a_signed2), .b_signed(b_signed2), .in_tag(in_tag2),
    .out_valid(out_valid2), .out_ready(out_ready2), .y(y2), .out_tag(out_tag2)
  );

  typedef struct {
    logic [31:0] y;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [31:0] exp_y1, exp_y2;
  bit          lat1, lat2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for the 3-stage build, including stall-hold and ready checks.
  int          cnt1   = 0;
  bit          seen1  = 1'b0;
  bit          stall1 = 1'b0;
  logic [15:0] py1;
  logic [3:0]  pt1;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q1.delete();
      cnt1 = 0; seen1 = 1'b0; stall1 = 1'b0;
    end else begin
      check("in_ready1", in_ready1, (cnt1 < S1) || out_ready1);
      if (stall1) begin
        check("hold_valid1", out_valid1, 1'b1);
        check("hold_y1", y1, py1);
        check("hold_tag1", out_tag1, pt1);
      end
      if (out_valid1 && !seen1 && q1.size() > 0) begin
        seen1 = 1'b1;
        if (q1[0].lat) check("latency1", cyc - q1[0].acc, S1);
      end
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out1: got y=0x%0h tag=0x%0h expected no output", y1, out_tag1);
        end else begin
          e = q1.pop_front();
          check("y1", y1, e.y);
          check("tag1", out_tag1, e.tag);
        end
        seen1 = 1'b0;
      end
      if (in_valid1 && in_ready1) q1.push_back('{exp_y1, in_tag1, cyc, lat1});
      cnt1   = cnt1 + int'(in_valid1 && in_ready1) - int'(out_valid1 && out_ready1);
      stall1 = out_valid1 && !out_ready1;
      py1    = y1;
      pt1    = out_tag1;
    end
  end

  // Monitor for the 1-stage, 16-bit build.
  int cnt2  = 0;
  bit seen2 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q2.delete();
      cnt2 = 0; seen2 = 1'b0;
    end else begin
      check("in_ready2", in_ready2, (cnt2 < S2) || out_ready2);
      if (out_valid2 && !seen2 && q2.size() > 0) begin
        seen2 = 1'b1;
        if (q2[0].lat) check("latency2", cyc - q2[0].acc, S2);
      end
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out2: got y=0x%0h tag=0x%0h expected no output", y2, out_tag2);
        end else begin
          e = q2.pop_front();
          check("y2", y2, e.y);
          check("tag2", out_tag2, e.tag);
        end
        seen2 = 1'b0;
      end
      if (in_valid2 && in_ready2) q2.push_back('{exp_y2, in_tag2, cyc, lat2});
      cnt2 = cnt2 + int'(in_valid2 && in_ready2) - int'(out_valid2 && out_ready2);
    end
  end

  task automatic send1(input logic [7:0] va, input logic [7:0] vb, input logic sa, input logic sb,
                       input logic [3:0] tag, input logic [15:0] ey, input bit lat);
    int w = 0;
    a1 = va; b1 = vb; a_signed1 = sa; b_signed1 = sb; in_tag1 = tag;
    exp_y1 = {16'h0, ey}; lat1 = lat; in_valid1 = 1'b1;
    @(negedge clk);
    while (!in_ready1 && w < 100) begin @(negedge clk); w++; end
    if (!in_ready1) begin
      total++; bad++;
      $display("FAIL send1_timeout: in_ready1=%0b expected 1 within 100 cycles", in_ready1);
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic send2(input logic [15:0] va, input logic [15:0] vb, input logic sa, input logic sb,
                       input logic [3:0] tag, input logic [31:0] ey, input bit lat);
    int w = 0;
    a2 = va; b2 = vb; a_signed2 = sa; b_signed2 = sb; in_tag2 = tag;
    exp_y2 = ey; lat2 = lat; in_valid2 = 1'b1;
    @(negedge clk);
    while (!in_ready2 && w < 100) begin
      @(posedge clk); #1;
      out_ready2 = 1'b1;
      @(negedge clk);
      w++;
    end
    if (!in_ready2) begin
      total++; bad++;
      $display("FAIL send2_timeout: in_ready2=%0b expected 1 within 100 cycles", in_ready2);
    end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; a_signed1 = 1'b0; b_signed1 = 1'b0; in_tag1 = '0; out_ready1 = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; a_signed2 = 1'b0; b_signed2 = 1'b0; in_tag2 = '0; out_ready2 = 1'b1;
    exp_y1 = '0; exp_y2 = '0; lat1 = 1'b0; lat2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid1", out_valid1, 1'b0);
    check("rst_y1", y1, 16'h0);
    check("rst_tag1", out_tag1, 4'h0);
    check("rst_in_ready1", in_ready1, 1'b1);
    check("rst_out_valid2", out_valid2, 1'b0);
    check("rst_y2", y2, 32'h0);
    @(posedge clk); #1;

    // Unsigned max operands with latency check
    send1(8'hFF, 8'hFF, 1'b0, 1'b0, 4'h5, 16'hFE01, 1'b1);
    idle(4);

    // Signed and mixed, back-to-back
    send1(8'h80, 8'h80, 1'b1, 1'b1, 4'h1, 16'h4000, 1'b1);
    send1(8'hFF, 8'h02, 1'b1, 1'b1, 4'h2, 16'hFFFE, 1'b1);
    send1(8'hFF, 8'hFF, 1'b1, 1'b0, 4'h3, 16'hFF01, 1'b1);
    send1(8'h7F, 8'h80, 1'b1, 1'b1, 4'h4, 16'hC080, 1'b1);
    idle(6);

    // Backpressure: out_ready pattern 1,0,0 while tags 0..7 stream in
    fork
      begin
        for (int t = 0; t < 8; t++)
          send1(8'(t + 1), 8'd3, 1'b0, 1'b0, 4'(t), 16'((t + 1) * 3), 1'b0);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready1 = (k % 3 == 0);
          @(posedge clk); #1;
        end
        out_ready1 = 1'b1;
      end
    join
    idle(6);

    // Bubble collapse with the output stalled
    out_ready1 = 1'b0;
    send1(8'h0A, 8'h0B, 1'b0, 1'b0, 4'h6, 16'h006E, 1'b0);
    idle(2);
    send1(8'h12, 8'h34, 1'b0, 1'b0, 4'h7, 16'h03A8, 1'b0);
    send1(8'hF0, 8'h10, 1'b1, 1'b0, 4'h8, 16'hFF00, 1'b0);
    @(negedge clk);
    check("full_in_ready", in_ready1, 1'b0);
    @(posedge clk); #1;
    out_ready1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drain_consecutive", out_valid1, 1'b1);
    end
    @(negedge clk);
    check("drain_empty", out_valid1, 1'b0);
    @(posedge clk); #1;

    // Reset with three held in flight
    out_ready1 = 1'b0;
    send1(8'h01, 8'h01, 1'b0, 1'b0, 4'h9, 16'h0001, 1'b0);
    send1(8'h02, 8'h02, 1'b0, 1'b0, 4'hA, 16'h0004, 1'b0);
    send1(8'h03, 8'h03, 1'b0, 1'b0, 4'hB, 16'h0009, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid1, 1'b0);
    check("midrst_y", y1, 16'h0);
    check("midrst_tag", out_tag1, 4'h0);
    @(posedge clk); #1;
    out_ready1 = 1'b1;
    idle(5);
    send1(8'h03, 8'hFD, 1'b1, 1'b1, 4'hC, 16'hFFF7, 1'b1);
    idle(5);

    // 16-bit single-stage build: directed, then randomised against a reference
    send2(16'hFFFF, 16'h8000, 1'b1, 1'b1, 4'h3, 32'h0000_8000, 1'b1);
    idle(2);
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] va, vb;
      logic        sa, sb;
      longint      av, bv, p;
      logic [63:0] pu;
      va = 16'($urandom);
      vb = 16'($urandom);
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      av = sa ? longint'($signed(va)) : longint'(va);
      bv = sb ? longint'($signed(vb)) : longint'(vb);
      p  = av * bv;
      pu = p;
      out_ready2 = ($urandom_range(0, 3) != 0);
      send2(va, vb, sa, sb, 4'(i), pu[31:0], 1'b0);
    end
    out_ready2 = 1'b1;

    begin
      int w = 0;
      while ((q1.size() != 0 || q2.size() != 0) && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (q1.size() != 0 || q2.size() != 0) begin
        total++; bad++;
        $display("FAIL drain: pending q1=%0d q2=%0d expected 0", q1.size(), q2.size());
      end
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
